// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and types for the seven-segment scan driver.
//   - segment patterns (active-low, bit order {dp,g,f,e,d,c,b,a})
//   - anode-select constants and helper (active-low, one-hot-low)
//   - BCD digit-slot type
package seg7_pkg;

    // One BCD digit slot.
    typedef logic [3:0] bcd_t;

    // Segment patterns, active-low {dp,g,f,e,d,c,b,a}; dp bit is off here.
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'b1100_0000,   // 0
        8'b1111_1001,   // 1
        8'b1010_0100,   // 2
        8'b1011_0000,   // 3
        8'b1001_1001,   // 4
        8'b1001_0010,   // 5
        8'b1000_0010,   // 6
        8'b1111_1000,   // 7
        8'b1000_0000,   // 8
        8'b1001_0000    // 9
    };
    localparam logic [7:0] SEG_DASH = 8'b1011_1111;   // only g lit
    localparam logic [7:0] SEG_E    = 8'b1000_0110;   // non-BCD input
    localparam logic [7:0] SEG_OFF  = 8'b1111_1111;

    // Anode drive, active-low.
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Anode pattern that enables exactly the digit at position pos.
    function automatic logic [3:0] an_sel(input logic [1:0] pos);
        an_sel = ~(4'b0001 << pos);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational BCD to seven-segment decoder for one digit slot.
// Ports:
//   bcd   in  4  digit value; values above 9 render as "E"
//   dash  in  1  render "-" instead of the digit (dp suppressed)
//   dp_en in  1  light the decimal point (ignored while dash)
//   seg   out 8  active-low segments {dp,g,f,e,d,c,b,a}
import seg7_pkg::*;

module seg7_decode (
    input  logic [3:0] bcd,
    input  logic       dash,
    input  logic       dp_en,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (dash) begin
            seg = SEG_DASH;
        end else begin
            if (bcd > 4'd9) seg = SEG_E;
            else            seg = SEG_DIGIT[bcd];
            // Decimal point also applies on top of "E".
            if (dp_en) seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes four BCD digits onto a 4-digit common-anode display.
// Owns scan timing, brightness duty, leading-zero blanking, decimal point,
// dash mode and tear-free (frame-aligned) input capture.
// Parameters:
//   TICK_DIV  clock cycles per digit slot (>= 8)
//   DP_POS    anode index carrying the decimal point (4 = none)
// Ports:
//   CLK          in  1   system clock
//   RST_N        in  1   asynchronous active-low reset
//   DIGITS       in  16  BCD digits, [15:12] -> AN[0] ... [3:0] -> AN[3]
//   DASH         in  1   show "-" on every digit
//   BLANK_LZ     in  1   enable leading-zero blanking
//   DIM          in  2   lit fraction of each slot = 1/2^DIM
//   SEG          out 8   active-low segments {dp,g,f,e,d,c,b,a}
//   AN           out 4   active-low anode enables
//   FRAME_START  out 1   one-cycle pulse after each shadow load
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int unsigned TICK_DIV = 10000,
    parameter int unsigned DP_POS   = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] DIGITS,
    input  logic        DASH,
    input  logic        BLANK_LZ,
    input  logic [1:0]  DIM,
    output logic [7:0]  SEG,
    output logic [3:0]  AN,
    output logic        FRAME_START
);

    localparam int unsigned     CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    // Scan state
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pos;
    logic             started;

    // Shadow copies of the inputs, only refreshed at frame boundaries
    bcd_t [3:0] sh_dig;
    logic       sh_dash;
    logic       sh_blz;
    logic [1:0] sh_dim;

    // Next-state values; outputs are decoded from these so SEG/AN line up
    // with the cnt/pos values registered on the same edge.
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       pos_nxt;
    logic             load;
    bcd_t [3:0]       dig_in;
    bcd_t [3:0]       sh_dig_nxt;
    logic             sh_dash_nxt;
    logic             sh_blz_nxt;
    logic [1:0]       sh_dim_nxt;

    logic [31:0]      win_len;
    logic             lit;
    logic             blank;
    logic             dp_en;
    bcd_t             cur_bcd;
    logic [7:0]       dec_seg;

    always_comb begin
        // The first edge after reset release only loads the shadows and
        // keeps the scan parked at pos 0 / cnt 0, so that first slot gets
        // its full TICK_DIV cycles like every other slot.
        load    = !started || (cnt == CNT_MAX && pos == 2'd3);
        cnt_nxt = cnt;
        pos_nxt = pos;
        if (!started) begin
            cnt_nxt = '0;
            pos_nxt = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            pos_nxt = pos + 2'd1;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_comb begin
        dig_in = '0;
        for (int i = 0; i < 4; i++) begin
            dig_in[i] = DIGITS[15-4*i -: 4];
        end
        sh_dig_nxt  = load ? dig_in   : sh_dig;
        sh_dash_nxt = load ? DASH     : sh_dash;
        sh_blz_nxt  = load ? BLANK_LZ : sh_blz;
        sh_dim_nxt  = load ? DIM      : sh_dim;
    end

    always_comb begin
        // Brightness window; a zero-length window leaves the display dark.
        win_len = TICK_DIV >> sh_dim_nxt;
        lit     = {{(32-CNT_W){1'b0}}, cnt_nxt} < win_len;

        // Leading zeros are blanked only left of the decimal point.
        blank = 1'b0;
        if (sh_blz_nxt && !sh_dash_nxt) begin
            if (pos_nxt == 2'd0 && DP_POS > 0 && sh_dig_nxt[0] == 4'd0)
                blank = 1'b1;
            if (pos_nxt == 2'd1 && DP_POS > 1 &&
                sh_dig_nxt[0] == 4'd0 && sh_dig_nxt[1] == 4'd0)
                blank = 1'b1;
        end

        cur_bcd = sh_dig_nxt[pos_nxt];
        dp_en   = ({30'd0, pos_nxt} == DP_POS) && !blank;
    end

    seg7_decode u_decode (
        .bcd   (cur_bcd),
        .dash  (sh_dash_nxt),
        .dp_en (dp_en),
        .seg   (dec_seg)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt         <= '0;
            pos         <= '0;
            started     <= 1'b0;
            sh_dig      <= '0;
            sh_dash     <= 1'b0;
            sh_blz      <= 1'b0;
            sh_dim      <= '0;
            SEG         <= SEG_OFF;
            AN          <= AN_OFF;
            FRAME_START <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            pos         <= pos_nxt;
            started     <= 1'b1;
            sh_dig      <= sh_dig_nxt;
            sh_dash     <= sh_dash_nxt;
            sh_blz      <= sh_blz_nxt;
            sh_dim      <= sh_dim_nxt;
            FRAME_START <= load;
            if (lit && !blank) begin
                AN  <= an_sel(pos_nxt);
                SEG <= dec_seg;
            end else begin
                AN  <= AN_OFF;
                SEG <= SEG_OFF;
            end
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the taxi meter: takes four BCD fare digits plus display-mode controls and time-multiplexes them onto one 4-digit common-anode seven-segment display.
- Replaces the ad-hoc scan case statements inside the meter. The meter only presents digit values; this block owns scan timing, brightness duty, leading-zero blanking, decimal point, dash mode and tear-free updates.

Parameters:
- TICK_DIV, 10000, clock cycles per digit slot (>= 8, power of two not required).
- DP_POS, 2, anode index whose decimal point is lit (0..3; 4 = no DP).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- DIGITS  in  16  BCD digits; [15:12] drives AN[0] (most significant), [11:8] AN[1], [7:4] AN[2], [3:0] AN[3]
- DASH  in  1  show "-" on all four digits (fare-settled display)
- BLANK_LZ  in  1  enable leading-zero blanking
- DIM  in  2  brightness level; lit fraction = 1/2^DIM of each slot
- SEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- AN  out  4  active-low anode enables, one-hot-low or all high
- FRAME_START  out  1  one-cycle pulse after each shadow load

Behaviour:
- Reset is asynchronous and active-low; clock is CLK, reset is RST_N. During reset: SEG=8'hFF, AN=4'b1111, FRAME_START=0, cnt=0, pos=0, shadow digits=0, shadow DASH/BLANK_LZ/DIM=0.
- Counters:
  - cnt runs 0..TICK_DIV-1.
  - At cnt==TICK_DIV-1: cnt returns to 0 and pos (2 bits) increments, wrapping 3->0.
  - One frame = 4*TICK_DIV cycles.
- Shadow load (tear-free update):
  - DIGITS, DASH, BLANK_LZ and DIM are captured into shadow registers on the edge where pos wraps 3->0, and also on the first rising edge after RST_N deasserts.
  - All decode uses shadow values only. Input changes mid-frame never alter the current frame.
  - FRAME_START is high in the cycle immediately after each load edge.
- Anode drive:
  - AN and SEG are registered and update on the same edge that pos/cnt take their new values.
  - Lit window per slot is cnt < (TICK_DIV >> DIM); in that window AN[pos]=0 and the other anodes are 1.
  - Outside the window AN=4'b1111 and SEG=8'hFF.
  - If (TICK_DIV >> DIM) == 0, the display is permanently dark.
- Segment decode for the digit at position p (priority order):
  1. Shadow DASH: SEG=8'b1011_1111. No blanking, no DP.
  2. BCD > 9: "E" = 8'b1000_0110.
  3. Otherwise the standard table, 0 = 8'b1100_0000 through 9 = 8'b1001_0000.
- Leading-zero blanking (shadow BLANK_LZ=1, DASH=0):
  - Position 0 is blanked (AN held 4'b1111 for that slot) if its digit is 0.
  - Position 1 is blanked if digits 0 and 1 are both 0.
  - Positions >= DP_POS, and position 3, are never blanked.
- Decimal point:
  - When p==DP_POS and not DASH and not blanked, SEG[7] is forced to 0.
  - Applies to "E" as well.
- Reset mid-frame: outputs go dark immediately (asynchronously). After release, the first frame starts at pos 0 with freshly loaded shadows.
- Width rules: cnt is $clog2(TICK_DIV) bits and never exceeds TICK_DIV-1. DIM shift uses the unsigned parameter value.

Decomposition:
- Shared package seg7_pkg holds:
  - segment constants SEG_DIGIT[0:9], SEG_DASH, SEG_E, SEG_OFF;
  - anode-select constants;
  - the digit-slot type (4-bit BCD).
- One natural sub-module: seg7_decode, combinational, with inputs bcd[3:0], dash, dp_en and output seg[7:0]. It is instantiated once and fed by the pos mux.
- Counters, shadow registers, blanking and windowing live in the top module.

Test Plan (TICK_DIV=8, DP_POS=2):
1. Reset then DIGITS=16'h0125, BLANK_LZ=1, DIM=0, DASH=0 -> AN[0] slot stays dark. AN=1101 shows "1" (8'b1111_1001). AN=1011 shows "2." (8'b0010_0100). AN=0111 shows "5" (8'b1001_0010). Each slot lasts 8 cycles. FRAME_START pulses once every 32 cycles.
2. DIGITS=16'h0005, BLANK_LZ=1 -> positions 0 and 1 dark; position 2 shows "0." (8'b0100_0000). Repeat with BLANK_LZ=0 -> position 0 shows 8'b1100_0000.
3. DASH=1 -> all four slots show 8'b1011_1111, no DP, no blanking, even with DIGITS=0.
4. DIM=2 -> each AN low for exactly 2 cycles (cnt 0..1), then 6 cycles of AN=1111, SEG=FF. DIM=3 -> 1 cycle lit.
5. Change DIGITS from 16'h1234 to 16'h9876 while pos=1 -> rest of the frame still shows 3 and 4. Next frame shows 9,8,7.,6 starting with the slot after FRAME_START.
6. DIGITS=16'hA000; separately, assert RST_N=0 at pos=2, cnt=3 -> position 0 shows 8'b1000_0110. Under reset, AN=1111 and SEG=FF in the same cycle without waiting for a clock edge. After release, scan restarts at pos 0 and cnt 0.
